// File: rtl/di_ei_pkg.sv
// di_ei_pkg: CORDIC e_i constants, unsigned, 32 fraction bits.
// Entries past the 32-bit resolution read as zero.
package di_ei_pkg;

    typedef enum logic [1:0] {
        COORD_LINEAR     = 2'b00,
        COORD_CIRCULAR   = 2'b01,
        COORD_RESERVED   = 2'b10,
        COORD_HYPERBOLIC = 2'b11
    } coord_sys_e;

    localparam int CORDIC_LUT_DEPTH = 64;
    localparam int K_FRAC = 32;
    localparam int K_W = K_FRAC + 1;

    typedef logic [K_W-1:0] k_t;

    // atan(2^-i); from i = 11 the cubic term is below half an LSB
    localparam k_t ATAN_TBL [CORDIC_LUT_DEPTH] = '{
        0: 33'd3373259426, 1: 33'd1991351318,
        2: 33'd1052175346, 3: 33'd534100635,
        4: 33'd268086748,  5: 33'd134174063,
        6: 33'd67103403,   7: 33'd33553749,
        8: 33'd16777131,   9: 33'd8388597,
        10: 33'd4194303,
        11: 33'd1 << 21, 12: 33'd1 << 20, 13: 33'd1 << 19,
        14: 33'd1 << 18, 15: 33'd1 << 17, 16: 33'd1 << 16,
        17: 33'd1 << 15, 18: 33'd1 << 14, 19: 33'd1 << 13,
        20: 33'd1 << 12, 21: 33'd1 << 11, 22: 33'd1 << 10,
        23: 33'd1 << 9,  24: 33'd1 << 8,  25: 33'd1 << 7,
        26: 33'd1 << 6,  27: 33'd1 << 5,  28: 33'd1 << 4,
        29: 33'd1 << 3,  30: 33'd1 << 2,  31: 33'd1 << 1,
        32: 33'd1,
        default: 33'd0
    };

    // 2^-i; 2^-33 is an exact half LSB and rounds away from zero
    localparam k_t LIN_TBL [CORDIC_LUT_DEPTH] = '{
        0: 33'd1 << 32,
        1: 33'd1 << 31,  2: 33'd1 << 30,  3: 33'd1 << 29,
        4: 33'd1 << 28,  5: 33'd1 << 27,  6: 33'd1 << 26,
        7: 33'd1 << 25,  8: 33'd1 << 24,  9: 33'd1 << 23,
        10: 33'd1 << 22, 11: 33'd1 << 21, 12: 33'd1 << 20,
        13: 33'd1 << 19, 14: 33'd1 << 18, 15: 33'd1 << 17,
        16: 33'd1 << 16, 17: 33'd1 << 15, 18: 33'd1 << 14,
        19: 33'd1 << 13, 20: 33'd1 << 12, 21: 33'd1 << 11,
        22: 33'd1 << 10, 23: 33'd1 << 9,  24: 33'd1 << 8,
        25: 33'd1 << 7,  26: 33'd1 << 6,  27: 33'd1 << 5,
        28: 33'd1 << 4,  29: 33'd1 << 3,  30: 33'd1 << 2,
        31: 33'd1 << 1,  32: 33'd1,       33: 33'd1,
        default: 33'd0
    };

    // atanh(2^-i); i = 0 is unbounded and never selected
    localparam k_t ATANH_TBL [CORDIC_LUT_DEPTH] = '{
        0: 33'd0,
        1: 33'd2359251925, 2: 33'd1096989674,
        3: 33'd539693625,  4: 33'd268785803,
        5: 33'd134261444,  6: 33'd67114326,
        7: 33'd33555115,   8: 33'd16777301,
        9: 33'd8388619,    10: 33'd4194305,
        11: 33'd1 << 21, 12: 33'd1 << 20, 13: 33'd1 << 19,
        14: 33'd1 << 18, 15: 33'd1 << 17, 16: 33'd1 << 16,
        17: 33'd1 << 15, 18: 33'd1 << 14, 19: 33'd1 << 13,
        20: 33'd1 << 12, 21: 33'd1 << 11, 22: 33'd1 << 10,
        23: 33'd1 << 9,  24: 33'd1 << 8,  25: 33'd1 << 7,
        26: 33'd1 << 6,  27: 33'd1 << 5,  28: 33'd1 << 4,
        29: 33'd1 << 3,  30: 33'd1 << 2,  31: 33'd1 << 1,
        32: 33'd1,       33: 33'd1,
        default: 33'd0
    };

endpackage

// File: rtl/di_ei_round_sat.sv
// di_ei_round_sat: 32-fraction-bit constant to BIT_WIDTH code.
// Round half away from zero, clamp at the largest positive code.
module di_ei_round_sat
    import di_ei_pkg::*;
#(
    parameter int WHOLE_BIT_WIDTH = 4,
    parameter int BIT_WIDTH       = 6
) (
    input  logic [K_W-1:0]       k_in,
    output logic [BIT_WIDTH-1:0] code_out
);

    localparam int FRAC = BIT_WIDTH - WHOLE_BIT_WIDTH;
    localparam int DROP = K_FRAC - FRAC;
    localparam logic [63:0] HALF = 64'd1 << (DROP - 1);
    localparam logic [63:0] MAX_CODE = (64'd1 << (BIT_WIDTH - 1)) - 64'd1;

    logic [63:0] rnd;

    // Constants are non-negative, so adding half rounds ties upward
    always_comb begin
        rnd = ({31'd0, k_in} + HALF) >> DROP;
        code_out = (rnd > MAX_CODE) ? MAX_CODE[BIT_WIDTH-1:0]
                                    : rnd[BIT_WIDTH-1:0];
    end

endmodule

// File: rtl/di_ei_lut.sv
// di_ei_lut: registered CORDIC e_i lookup, one cycle latency.
// DI_EI_LUT_HYPERBOLIC_EN builds the atanh table and enables 2'b11.
module di_ei_lut
    import di_ei_pkg::*;
#(
    parameter int WHOLE_BIT_WIDTH = 4,
    parameter int BIT_WIDTH       = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           count_in,
    input  logic [1:0]           coordinate_system_in,
    output logic [BIT_WIDTH-1:0] di_ei_output_out,
    output logic                 di_ei_valid_out
);

    logic [BIT_WIDTH-1:0] circ_code [CORDIC_LUT_DEPTH];
    logic [BIT_WIDTH-1:0] lin_code  [CORDIC_LUT_DEPTH];
`ifdef DI_EI_LUT_HYPERBOLIC_EN
    logic [BIT_WIDTH-1:0] hyp_code  [CORDIC_LUT_DEPTH];
`endif

    logic [BIT_WIDTH-1:0] di_ei_d;
    logic [BIT_WIDTH-1:0] di_ei_q;
    logic                 valid_d;
    logic                 valid_q;
    coord_sys_e           sel;

    // Every entry is a constant, so these instances fold to wiring
    for (genvar g = 0; g < CORDIC_LUT_DEPTH; g++) begin : g_ent
        di_ei_round_sat #(
            .WHOLE_BIT_WIDTH(WHOLE_BIT_WIDTH),
            .BIT_WIDTH      (BIT_WIDTH)
        ) u_circ (
            .k_in    (ATAN_TBL[g]),
            .code_out(circ_code[g])
        );
        di_ei_round_sat #(
            .WHOLE_BIT_WIDTH(WHOLE_BIT_WIDTH),
            .BIT_WIDTH      (BIT_WIDTH)
        ) u_lin (
            .k_in    (LIN_TBL[g]),
            .code_out(lin_code[g])
        );
`ifdef DI_EI_LUT_HYPERBOLIC_EN
        di_ei_round_sat #(
            .WHOLE_BIT_WIDTH(WHOLE_BIT_WIDTH),
            .BIT_WIDTH      (BIT_WIDTH)
        ) u_hyp (
            .k_in    (ATANH_TBL[g]),
            .code_out(hyp_code[g])
        );
`endif
    end

    assign sel = coord_sys_e'(coordinate_system_in);

    // Select this iteration's entry; illegal selections read as zero
    always_comb begin
        di_ei_d = '0;
        valid_d = 1'b0;
        unique case (sel)
            COORD_CIRCULAR: begin
                di_ei_d = circ_code[count_in];
                valid_d = 1'b1;
            end
            COORD_LINEAR: begin
                di_ei_d = lin_code[count_in];
                valid_d = 1'b1;
            end
`ifdef DI_EI_LUT_HYPERBOLIC_EN
            COORD_HYPERBOLIC: begin
                if (count_in != 6'd0) begin
                    di_ei_d = hyp_code[count_in];
                    valid_d = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Output register; reset discards any pending lookup
    always_ff @(posedge clk) begin
        if (rst) begin
            di_ei_q <= '0;
            valid_q <= 1'b0;
        end else begin
            di_ei_q <= di_ei_d;
            valid_q <= valid_d;
        end
    end

    assign di_ei_output_out = di_ei_q;
    assign di_ei_valid_out  = valid_q;

endmodule

// File: tb/tb_di_ei_lut.sv
// tb_di_ei_lut: directed checks of di_ei_lut at 4.2 and 2.2 formats.
// Expected codes are hand-rounded real values.
module tb_di_ei_lut;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] count_in = 6'd5;
    logic [1:0] coordinate_system_in = 2'b01;
    logic [5:0] out6;
    logic       v6;
    logic [3:0] out4;
    logic       v4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    di_ei_lut #(
        .WHOLE_BIT_WIDTH(4),
        .BIT_WIDTH      (6)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .count_in            (count_in),
        .coordinate_system_in(coordinate_system_in),
        .di_ei_output_out    (out6),
        .di_ei_valid_out     (v6)
    );

    di_ei_lut #(
        .WHOLE_BIT_WIDTH(2),
        .BIT_WIDTH      (4)
    ) dut_n (
        .clk                 (clk),
        .rst                 (rst),
        .count_in            (count_in),
        .coordinate_system_in(coordinate_system_in),
        .di_ei_output_out    (out4),
        .di_ei_valid_out     (v4)
    );

    task automatic step(input logic [1:0] cs, input logic [5:0] cnt);
        coordinate_system_in = cs;
        count_in = cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(2'b01, 6'(k + 5));
            n_vec++;
            if (out6 !== 6'd0 || v6 !== 1'b0) begin
                n_err++;
                $display("FAIL reset_%0d: got %b/%b want 000000/0",
                         k, out6, v6);
            end
        end
        rst = 1'b0;
        step(2'b01, 6'd0);
        n_vec++;
        if (out6 !== 6'b000011 || v6 !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset: got %b/%b want 000011/1", out6, v6);
        end
    endtask

    task automatic test_circular();
        logic [5:0] exp_c [7] = '{3, 2, 1, 0, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            step(2'b01, 6'(i));
            n_vec++;
            if (out6 !== exp_c[i] || v6 !== 1'b1) begin
                n_err++;
                $display("FAIL circ_%0d: got %0d/%b want %0d/1",
                         i, out6, v6, exp_c[i]);
            end
        end
        step(2'b01, 6'd63);
        n_vec++;
        if (out6 !== 6'd0 || v6 !== 1'b1) begin
            n_err++;
            $display("FAIL circ_63: got %0d/%b want 0/1", out6, v6);
        end
    endtask

    task automatic test_linear();
        logic [5:0] exp_l [5] = '{4, 2, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            step(2'b00, 6'(i));
            n_vec++;
            if (out6 !== exp_l[i] || v6 !== 1'b1) begin
                n_err++;
                $display("FAIL lin_%0d: got %0d/%b want %0d/1",
                         i, out6, v6, exp_l[i]);
            end
        end
    endtask

    task automatic test_hyperbolic();
`ifdef DI_EI_LUT_HYPERBOLIC_EN
        logic [5:0] exp_h [4] = '{0, 2, 1, 1};
        logic       exp_v [4] = '{0, 1, 1, 1};
`else
        logic [5:0] exp_h [4] = '{0, 0, 0, 0};
        logic       exp_v [4] = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 6'(i));
            n_vec++;
            if (out6 !== exp_h[i] || v6 !== exp_v[i]) begin
                n_err++;
                $display("FAIL hyp_%0d: got %0d/%b want %0d/%b",
                         i, out6, v6, exp_h[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_reserved();
        step(2'b10, 6'd1);
        n_vec++;
        if (out6 !== 6'd0 || v6 !== 1'b0) begin
            n_err++;
            $display("FAIL rsv_1: got %0d/%b want 0/0", out6, v6);
        end
        step(2'b10, 6'd0);
        n_vec++;
        if (out6 !== 6'd0 || v6 !== 1'b0) begin
            n_err++;
            $display("FAIL rsv_0: got %0d/%b want 0/0", out6, v6);
        end
    endtask

    task automatic test_hold();
        step(2'b00, 6'd0);
        coordinate_system_in = 2'b01;
        count_in = 6'd3;
        #3;
        n_vec++;
        if (out6 !== 6'd4 || v6 !== 1'b1) begin
            n_err++;
            $display("FAIL hold: got %0d/%b want 4/1", out6, v6);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (out6 !== 6'd0 || v6 !== 1'b1) begin
            n_err++;
            $display("FAIL hold_next: got %0d/%b want 0/1", out6, v6);
        end
    endtask

    task automatic test_narrow();
        logic [1:0] cs [4] = '{2'b00, 2'b01, 2'b01, 2'b00};
        logic [5:0] ct [4] = '{0, 0, 1, 3};
        // 1.0 at 2 fraction bits is 4, under the 1.75 (7) ceiling
        logic [3:0] ex [4] = '{4'b0100, 4'b0011, 4'b0010, 4'b0001};
        for (int k = 0; k < 4; k++) begin
            step(cs[k], ct[k]);
            n_vec++;
            if (out4 !== ex[k] || v4 !== 1'b1) begin
                n_err++;
                $display("FAIL narrow_%0d: got %b/%b want %b/1",
                         k, out4, v4, ex[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(2'b00, 6'd0);
        step(2'b00, 6'd1);
        rst = 1'b1;
        step(2'b00, 6'd0);
        n_vec++;
        if (out6 !== 6'd0 || v6 !== 1'b0 || out4 !== 4'd0) begin
            n_err++;
            $display("FAIL rst_mid: got %0d/%b/%0d want 0/0/0",
                     out6, v6, out4);
        end
        rst = 1'b0;
        step(2'b00, 6'd2);
        n_vec++;
        if (out6 !== 6'd1 || v6 !== 1'b1) begin
            n_err++;
            $display("FAIL rst_rel: got %0d/%b want 1/1", out6, v6);
        end
    endtask

    initial begin
        test_reset();
        test_circular();
        test_linear();
        test_hyperbolic();
        test_reserved();
        test_hold();
        test_narrow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
